// File: rtl/matrix_inv_pkg.sv
// Shared constants and the sequencer state encoding for the matrix inverter host path.
package matrix_inv_pkg;

  localparam int DW        = 16;
  localparam int MAX_ORDER = 16;
  localparam int TIMEOUT   = 4096;
  // Index counter must reach TOTAL+1 (feed pre-fetch runs two elements ahead).
  localparam int IDX_W     = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CRST,
    ST_ARM,
    ST_FEED,
    ST_WAIT,
    ST_CAP,
    ST_DRAIN,
    ST_FIN
  } state_t;

endpackage

// File: rtl/seq_buffer.sv
// Single-port-write / single-port-read synchronous RAM with one-cycle read latency.
// A read of the address being written returns the new data.
module seq_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= (we && (wa == ra)) ? wd : mem[ra];
  end

endmodule

// File: rtl/matrix_inv_sequencer.sv
// Host-side sequencer for the matrix inverter core: buffers an NxN matrix, replays it into
// the core, captures the core's unthrottled inverse and re-streams it under backpressure.
module matrix_inv_sequencer #(
  parameter int DW        = matrix_inv_pkg::DW,
  parameter int MAX_ORDER = matrix_inv_pkg::MAX_ORDER,
  parameter int TIMEOUT   = matrix_inv_pkg::TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    cfg_order,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic          timeout_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          core_rst_n,
  output logic [3:0]    core_order,
  output logic [DW-1:0] core_matrix_data,
  input  logic [DW-1:0] core_inv_data,
  input  logic          core_ready,
  input  logic          core_invertible,
  output logic [3:0]    dbg_state
);
  import matrix_inv_pkg::*;

  localparam int DEPTH = MAX_ORDER * MAX_ORDER;
  localparam int AW    = $clog2(DEPTH);
  localparam int WCW   = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  // Streams use valid/ready: a beat transfers on a rising clk edge where both are high;
  // the source holds valid and data stable until that edge.

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   total;
  logic [WCW-1:0]     wait_cnt;
  logic [4:0]         order_q;
  logic [DW-1:0]      rd_data;
  logic               buf_we;
  logic [DW-1:0]      buf_wd;
  logic               order_legal;
  logic               load_last, feed_last, cap_last, drain_last, total_is_one;
  logic               cap_start;
  logic               unused_idx_hi;

  assign order_legal  = (cfg_order != 5'd0) && (int'(cfg_order) <= MAX_ORDER);
  assign total        = IDX_W'(order_q) * IDX_W'(order_q);
  assign total_is_one = (total == IDX_W'(1));
  assign load_last    = (idx == total - 1'b1);
  assign feed_last    = (idx == total + 1'b1);
  assign cap_last     = (idx == total - 1'b1);
  assign drain_last   = (idx == total - 1'b1);
  assign cap_start    = (state == ST_WAIT) && core_ready && core_invertible;
  assign core_order   = order_q[3:0];
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && order_legal) state_nxt = ST_LOAD;
      ST_LOAD:  if (in_valid && load_last) state_nxt = ST_CRST;
      ST_CRST:  if (wait_cnt == WCW'(1)) state_nxt = ST_ARM;
      ST_ARM:   state_nxt = ST_FEED;
      ST_FEED:  if (feed_last) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_ready) begin
          if (!core_invertible)  state_nxt = ST_FIN;
          else if (total_is_one) state_nxt = ST_DRAIN;
          else                   state_nxt = ST_CAP;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_FIN;
        end
      end
      ST_CAP:   if (cap_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_ready && drain_last) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE) && (state != ST_FIN);
    in_ready   = (state == ST_LOAD);
    out_valid  = (state == ST_DRAIN);
    out_last   = (state == ST_DRAIN) && drain_last;
    out_data   = (state == ST_DRAIN) ? rd_data : '0;
    core_rst_n = (state == ST_ARM) || (state == ST_FEED) ||
                 (state == ST_WAIT) || (state == ST_CAP);
  end

  // Read address leads the consumer by one cycle: element 0 is fetched while the last
  // capture is written, and a drain handshake fetches the following element.
  always_comb begin
    rd_idx = idx;
    if ((state == ST_WAIT) || (state == ST_CAP))   rd_idx = '0;
    else if ((state == ST_DRAIN) && out_ready)     rd_idx = idx + 1'b1;
  end

  assign buf_we = ((state == ST_LOAD) && in_valid) || cap_start || (state == ST_CAP);
  assign buf_wd = (state == ST_LOAD) ? in_data : core_inv_data;
  assign unused_idx_hi = ^{idx[IDX_W-1:AW], rd_idx[IDX_W-1:AW]};

  seq_buffer #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk (clk),
    .we  (buf_we),
    .wa  (idx[AW-1:0]),
    .wd  (buf_wd),
    .ra  (rd_idx[AW-1:0]),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx              <= '0;
      wait_cnt         <= '0;
      order_q          <= '0;
      core_matrix_data <= '0;
    end else begin
      wait_cnt <= '0;
      if ((state == ST_IDLE) && start && order_legal) order_q <= cfg_order;
      // Two-deep pre-fetch (RAM latency + output register) keeps FEED gap-free.
      if ((state == ST_ARM) || ((state == ST_FEED) && !feed_last)) core_matrix_data <= rd_data;
      else                                                         core_matrix_data <= '0;
      unique case (state)
        ST_LOAD:  if (in_valid) idx <= load_last ? '0 : idx + 1'b1;
        ST_CRST: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WCW'(1)) idx <= idx + 1'b1;
        end
        ST_ARM:   idx <= idx + 1'b1;
        ST_FEED:  idx <= feed_last ? '0 : idx + 1'b1;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (cap_start) idx <= total_is_one ? '0 : IDX_W'(1);
        end
        ST_CAP:   idx <= cap_last ? '0 : idx + 1'b1;
        ST_DRAIN: if (out_ready) idx <= idx + 1'b1;
        default:  idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done        <= 1'b0;
      singular    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= (state_nxt == ST_FIN) || ((state == ST_IDLE) && start && !order_legal);
      if ((state == ST_IDLE) && start) begin
        singular    <= 1'b0;
        timeout_err <= !order_legal;
      end else if ((state == ST_WAIT) && core_ready && !core_invertible) begin
        singular <= 1'b1;
      end else if ((state == ST_WAIT) && !core_ready && (wait_cnt == WAIT_LAST)) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_inv_sequencer.sv
// Bench for matrix_inv_sequencer with a behavioural inverter-core model and an output scoreboard.
`timescale 1ns/1ps
module tb_matrix_inv_sequencer;
  import matrix_inv_pkg::*;

  localparam int TB_TIMEOUT = 4096;
  localparam int CORE_LAT   = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [4:0]    cfg_order;
  logic          busy, done, singular, timeout_err;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          core_rst_n;
  logic [3:0]    core_order;
  logic [DW-1:0] core_matrix_data;
  logic [DW-1:0] core_inv_data = '0;
  logic          core_ready = 1'b0;
  logic          core_invertible = 1'b0;
  logic [3:0]    dbg_state;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] job_mat  [256];
  logic [DW-1:0] job_resp [256];
  int            m_tot = 0;
  bit            m_inv = 1'b0;
  bit            m_never = 1'b0;
  int            m_cc = 0;
  bit            rdy_random = 1'b0;
  int            beats_total = 0;
  int            wait_total = 0;
  int            beats_base = 0;
  int            wait_base = 0;

  matrix_inv_sequencer #(
    .DW        (DW),
    .MAX_ORDER (MAX_ORDER),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_order        (cfg_order),
    .busy             (busy),
    .done             (done),
    .singular         (singular),
    .timeout_err      (timeout_err),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .core_rst_n       (core_rst_n),
    .core_order       (core_order),
    .core_matrix_data (core_matrix_data),
    .core_inv_data    (core_inv_data),
    .core_ready       (core_ready),
    .core_invertible  (core_invertible),
    .dbg_state        (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: one idle cycle after reset release, then TOTAL elements consumed one per
  // cycle; CORE_LAT cycles later ready rises and the inverse streams out unthrottled.
  always @(negedge clk) begin
    int k;
    if (!core_rst_n) begin
      m_cc            = 0;
      core_ready      = 1'b0;
      core_invertible = 1'b0;
      core_inv_data   = '0;
    end else begin
      if ((m_cc >= 1) && (m_cc <= m_tot)) begin
        if (feed_q.size() == 0) check_val("feed_extra", 1, 0);
        else                    check_val("feed_data", core_matrix_data, feed_q.pop_front());
      end
      if (!m_never && (m_cc >= m_tot + CORE_LAT)) begin
        k               = m_cc - (m_tot + CORE_LAT);
        core_ready      = 1'b1;
        core_invertible = m_inv;
        core_inv_data   = (k < m_tot) ? job_resp[k] : '0;
      end
      m_cc++;
    end
  end

  // Output sink and scoreboard: ready chosen at negedge, a beat is accepted at the next posedge.
  always @(negedge clk) begin
    logic [DW:0]   e;
    logic [DW-1:0] held;
    bit            stall_prev;
    bit            r;
    if (!rst) begin
      stall_prev = 1'b0;
      out_ready  = 1'b0;
    end else begin
      if (dbg_state == ST_WAIT) wait_total++;
      if (stall_prev) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, held);
      end
      r = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        beats_total++;
        if (exp_q.size() == 0) begin
          check_val("out_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_data", out_data, e[DW-1:0]);
          check_val("out_last", out_last, e[DW]);
        end
      end
      stall_prev = out_valid && !r;
      held       = out_data;
    end
  end

  task automatic begin_job(input int n, input bit inv, input bit never);
    int tot;
    tot     = n * n;
    m_tot   = tot;
    m_inv   = inv;
    m_never = never;
    for (int i = 0; i < tot; i++) begin
      feed_q.push_back(job_mat[i]);
      if (inv && !never) exp_q.push_back({(i == tot - 1), job_resp[i]});
    end
    beats_base = beats_total;
    wait_base  = wait_total;
    start      = 1'b1;
    cfg_order  = 5'(n);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("status_cleared", {singular, timeout_err}, 0);
    check_val("core_order", core_order, n % 16);
  endtask

  task automatic load_matrix(input int n);
    int  guard;
    bit  acc;
    for (int i = 0; i < n * n; i++) begin
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = job_mat[i];
        acc      = in_valid && in_ready;
        @(negedge clk);
        guard++;
        if (!acc && (guard > 100)) begin
          check_val("load_stall", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic finish_job(input int limit, input bit exp_sing, input bit exp_to, input int exp_beats);
    bit seen;
    seen = 1'b0;
    for (int c = 0; (c < limit) && !seen; c++) begin
      if (done) seen = 1'b1;
      else      @(negedge clk);
    end
    check_val("done_seen", seen, 1);
    if (seen) begin
      check_val("singular", singular, exp_sing);
      check_val("timeout_err", timeout_err, exp_to);
      check_val("busy_at_done", busy, 0);
      check_val("core_rst_at_done", core_rst_n, 0);
      @(negedge clk);
      check_val("done_pulse", done, 0);
      check_val("singular_hold", singular, exp_sing);
      check_val("beats", beats_total - beats_base, exp_beats);
      check_val("exp_left", exp_q.size(), 0);
      check_val("feed_left", feed_q.size(), 0);
    end
  endtask

  task automatic run_job(input int n, input bit inv, input bit never, input bit exp_sing,
                         input bit exp_to, input int exp_beats, input int limit);
    begin_job(n, inv, never);
    load_matrix(n);
    finish_job(limit, exp_sing, exp_to, exp_beats);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_orders [2];
    int guard;
    bad_orders = '{0, 17};
    rst       = 1'b0;
    start     = 1'b0;
    cfg_order = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_status", {singular, timeout_err}, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out", {out_valid, out_last}, 0);
    check_val("rst_core_rst_n", core_rst_n, 0);
    check_val("rst_core_data", core_matrix_data, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // 2x2 unimodular matrix and its inverse.
    job_mat[0] = 16'd1; job_mat[1] = 16'd1; job_mat[2] = 16'd0; job_mat[3] = 16'd1;
    job_resp[0] = 16'd1; job_resp[1] = 16'hFFFF; job_resp[2] = 16'd0; job_resp[3] = 16'd1;
    run_job(2, 1'b1, 1'b0, 1'b0, 1'b0, 4, 200);

    // Singular 2x2: no output beats.
    job_mat[0] = 16'd1; job_mat[1] = 16'd2; job_mat[2] = 16'd2; job_mat[3] = 16'd4;
    run_job(2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 200);

    // 3x3 identity under random backpressure.
    for (int i = 0; i < 9; i++) begin
      job_mat[i]  = (i % 4 == 0) ? 16'd1 : 16'd0;
      job_resp[i] = job_mat[i];
    end
    rdy_random = 1'b1;
    run_job(3, 1'b1, 1'b0, 1'b0, 1'b0, 9, 400);
    rdy_random = 1'b0;

    // Core never raises ready.
    job_mat[0] = 16'd3; job_mat[1] = 16'd7; job_mat[2] = 16'd9; job_mat[3] = 16'd2;
    run_job(2, 1'b1, 1'b1, 1'b0, 1'b1, 0, TB_TIMEOUT + 200);
    check_val("timeout_cycles", wait_total - wait_base, TB_TIMEOUT);

    // Illegal orders end at once with timeout_err.
    for (int b = 0; b < 2; b++) begin
      start     = 1'b1;
      cfg_order = 5'(bad_orders[b]);
      @(negedge clk);
      start = 1'b0;
      check_val("bad_order_done", done, 1);
      check_val("bad_order_err", timeout_err, 1);
      check_val("bad_order_busy", busy, 0);
      check_val("bad_order_state", dbg_state, ST_IDLE);
      @(negedge clk);
      check_val("bad_order_pulse", done, 0);
    end

    // Largest order: 256 elements through load, feed, capture and drain.
    for (int i = 0; i < 256; i++) begin
      job_mat[i]  = 16'($urandom_range(0, 65535));
      job_resp[i] = 16'($urandom_range(0, 65535));
    end
    run_job(16, 1'b1, 1'b0, 1'b0, 1'b0, 256, 2000);

    // Reset in the middle of FEED, then a clean 1x1 job.
    for (int i = 0; i < 9; i++) job_mat[i] = 16'($urandom_range(0, 65535));
    begin_job(3, 1'b1, 1'b0);
    load_matrix(3);
    guard = 0;
    while ((dbg_state != ST_FEED) && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    check_val("reached_feed", dbg_state, ST_FEED);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_core_rst_n", core_rst_n, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_handshakes", {in_ready, out_valid}, 0);
    check_val("abort_core_data", core_matrix_data, 0);
    @(negedge clk);
    rst = 1'b1;
    feed_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_val("abort_state", dbg_state, ST_IDLE);
    job_mat[0]  = 16'd5;
    job_resp[0] = 16'd1;
    run_job(1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 200);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
